// File: rtl/grid_pkg.sv
// Shared constants and helpers for the 5x5 window edge detector.
// Tap (row, col) of the packed window sits at bit offset grid_offset(row, col, width).
package grid_pkg;

   localparam int c_win        = 5;
   localparam int c_taps       = 25;
   localparam int c_int_width  = 8;
   localparam int c_grad_width = 14;

   localparam int c_row_weight [c_win] = '{1, 2, 4, 2, 1};

   // MSB-first packing: tap x00 occupies the top slice, x44 the bottom one.
   function automatic int grid_offset(input int row, input int col, input int width);
      return (24 - (5 * row + col)) * width;
   endfunction

endpackage

// File: rtl/grid_edge_detect_if.sv
// Window-buffer to edge-detector link: packed 5x5 window in, one pixel stream out.
interface grid_edge_detect_if #(
   parameter int p_bit_width_in = 24
);
   logic                          clken;
   logic                          iSof;
   logic                          iEdgeEn;
   logic [p_bit_width_in*25-1:0]  iGrid;
   logic [p_bit_width_in-1:0]     oPixel;
   logic                          oEdge;
   logic                          oValid;

   modport master (
      output clken, iSof, iEdgeEn, iGrid,
      input  oPixel, oEdge, oValid
   );

   modport slave (
      input  clken, iSof, iEdgeEn, iGrid,
      output oPixel, oEdge, oValid
   );
endinterface

// File: rtl/grid_edge_detect_rgb_to_intensity.sv
// Cheap luma approximation (R + 2G + B) / 4 for one packed RGB888 tap.
module rgb_to_intensity
   import grid_pkg::*;
(
   input  logic [23:0]             rgb,
   output logic [c_int_width-1:0]  intensity
);
   logic [9:0] sum;

   assign sum       = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
   assign intensity = sum[9:2];
endmodule

// File: rtl/grid_edge_detect.sv
// 5x5 Sobel-style edge detector: 3 clken-gated stages (intensity, gradient, decision)
// with frame coordinate tracking so windows spanning a line/frame wrap are never edges.
module grid_edge_detect
   import grid_pkg::*;
#(
   parameter int                         p_bit_width_in = 24,
   parameter int                         p_h_active     = 640,
   parameter int                         p_v_active     = 480,
   parameter logic [c_grad_width-1:0]    p_threshold    = 14'd2000,
   parameter logic [p_bit_width_in-1:0]  p_edge_color   = 24'h000000
)
(
   input  logic               clk,
   input  logic               rst_n,
   grid_edge_detect_if.slave  bus
);
   localparam int c_col_w = $clog2(p_h_active);
   localparam int c_row_w = $clog2(p_v_active);

   logic [c_col_w-1:0] col_reg, col_cur, col_next;
   logic [c_row_w-1:0] row_reg, row_cur, row_next;
   logic               border_now;

   logic [c_int_width-1:0]    int_tap [c_taps];
   logic [c_int_width-1:0]    int_reg [c_taps];
   logic [p_bit_width_in-1:0] centre_now;
   logic [p_bit_width_in-1:0] centre1_reg, centre2_reg;
   logic                      border1_reg, border2_reg;
   logic                      v1_reg, v2_reg;

   logic signed [c_grad_width-1:0] gx_next, gy_next, gx_reg, gy_reg;
   logic [c_grad_width-1:0]        abs_x, abs_y, mag;
   logic                           edge_hit;

   // ---------------- stage 1: per-tap intensity ----------------
   generate
      for (genvar gi = 0; gi < c_taps; gi++) begin : g_tap
         localparam int c_off = grid_offset(gi / c_win, gi % c_win, p_bit_width_in);
         rgb_to_intensity u_int (
            .rgb       (bus.iGrid[c_off +: p_bit_width_in]),
            .intensity (int_tap[gi])
         );
      end
   endgenerate

   assign centre_now = bus.iGrid[grid_offset(2, 2, p_bit_width_in) +: p_bit_width_in];

   // Start of frame rewrites the coordinate of the pixel being sampled right now.
   always_comb begin
      col_cur    = bus.iSof ? '0 : col_reg;
      row_cur    = bus.iSof ? '0 : row_reg;
      border_now = (col_cur < c_col_w'(4)) | (row_cur < c_row_w'(4)) | ~bus.iEdgeEn;
      col_next   = col_cur + 1'b1;
      row_next   = row_cur;
      if (col_cur == c_col_w'(p_h_active - 1)) begin
         col_next = '0;
         row_next = (row_cur == c_row_w'(p_v_active - 1)) ? '0 : row_cur + 1'b1;
      end
   end

   // ---------------- stage 2: weighted gradients ----------------
   always_comb begin
      gx_next = '0;
      gy_next = '0;
      for (int r = 0; r < c_win; r++) begin
         gx_next = gx_next + c_grad_width'(c_row_weight[r] *
                   (2 * (int'(int_reg[5*r+4]) - int'(int_reg[5*r+0]))
                    + int'(int_reg[5*r+3]) - int'(int_reg[5*r+1])));
         gy_next = gy_next + c_grad_width'(c_row_weight[r] *
                   (2 * (int'(int_reg[20+r]) - int'(int_reg[r]))
                    + int'(int_reg[15+r]) - int'(int_reg[5+r])));
      end
   end

   // ---------------- stage 3: magnitude and decision ----------------
   always_comb begin
      abs_x    = gx_reg[c_grad_width-1] ? c_grad_width'(-gx_reg) : c_grad_width'(gx_reg);
      abs_y    = gy_reg[c_grad_width-1] ? c_grad_width'(-gy_reg) : c_grad_width'(gy_reg);
      mag      = abs_x + abs_y;
      edge_hit = ~border2_reg & (mag >= p_threshold);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg     <= '0;
         row_reg     <= '0;
         for (int i = 0; i < c_taps; i++) int_reg[i] <= '0;
         centre1_reg <= '0;
         centre2_reg <= '0;
         border1_reg <= 1'b0;
         border2_reg <= 1'b0;
         v1_reg      <= 1'b0;
         v2_reg      <= 1'b0;
         gx_reg      <= '0;
         gy_reg      <= '0;
         bus.oPixel  <= '0;
         bus.oEdge   <= 1'b0;
         bus.oValid  <= 1'b0;
      end else begin
         bus.oValid <= bus.clken & v2_reg;
         if (bus.clken) begin
            col_reg     <= col_next;
            row_reg     <= row_next;
            for (int i = 0; i < c_taps; i++) int_reg[i] <= int_tap[i];
            centre1_reg <= centre_now;
            border1_reg <= border_now;
            v1_reg      <= 1'b1;

            gx_reg      <= gx_next;
            gy_reg      <= gy_next;
            centre2_reg <= centre1_reg;
            border2_reg <= border1_reg;
            v2_reg      <= v1_reg;

            // Outputs only move when a real result arrives, so they hold between pulses.
            if (v2_reg) begin
               bus.oPixel <= edge_hit ? p_edge_color : centre2_reg;
               bus.oEdge  <= edge_hit;
            end
         end
      end
   end

endmodule

// File: tb/tb_grid_edge_detect.sv
// Randomized bench for grid_edge_detect against an integer reference model of the window rules.
`timescale 1ns/1ps
module tb_grid_edge_detect;
   localparam int          W     = 24;
   localparam int          H     = 128;
   localparam int          V     = 12;
   localparam int          THR   = 2000;
   localparam logic [23:0] EDGEC = 24'hFF00FF;

   typedef logic [23:0] win_t [5][5];
   typedef struct { logic [23:0] pix; logic edge_flag; } res_t;

   logic clk = 1'b0;
   logic rst_n;
   grid_edge_detect_if #(.p_bit_width_in(W)) bus ();

   grid_edge_detect #(
      .p_bit_width_in (W),
      .p_h_active     (H),
      .p_v_active     (V),
      .p_threshold    (14'(THR)),
      .p_edge_color   (EDGEC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   win_t        win;
   res_t        exp_q[$];
   logic        exp_valid;
   logic [23:0] exp_pix;
   logic        exp_edge;
   int          mcol, mrow;
   int          nout = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int inten(input logic [23:0] p);
      return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
   endfunction

   function automatic res_t ref_result(input win_t w, input bit border);
      int   I [5][5];
      int   wr [5] = '{1, 2, 4, 2, 1};
      int   gx = 0, gy = 0, mag;
      res_t res;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) I[r][c] = inten(w[r][c]);
      for (int k = 0; k < 5; k++) begin
         gx += wr[k] * (2 * (I[k][4] - I[k][0]) + I[k][3] - I[k][1]);
         gy += wr[k] * (2 * (I[4][k] - I[0][k]) + I[3][k] - I[1][k]);
      end
      mag           = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      res.edge_flag = !border && (mag >= THR);
      res.pix       = res.edge_flag ? EDGEC : w[2][2];
      return res;
   endfunction

   // kinds: 0 random, 1 uniform grey, 2 vertical step, 3 mag 2000, 4 mag 1999, 5 smooth grey
   task automatic make_window(input int kind);
      int g;
      g = $urandom_range(0, 200);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            case (kind)
               0:       win[r][c] = 24'($urandom);
               1:       win[r][c] = 24'h808080;
               2:       win[r][c] = (c < 2) ? 24'h000000 : 24'hFFFFFF;
               3, 4:    win[r][c] = 24'h000000;
               default: win[r][c] = {3{8'(g + $urandom_range(0, 15))}};
            endcase
         end
      if (kind == 3) win[2][4] = 24'hFAFAFA;
      if (kind == 4) begin
         win[2][4] = 24'hFBFBFB;
         win[3][0] = 24'h030303;
      end
   endtask

   task automatic reset_model();
      exp_q.delete();
      exp_valid = 1'b0;
      exp_pix   = '0;
      exp_edge  = 1'b0;
      mcol      = 0;
      mrow      = 0;
   endtask

   task automatic check_outputs();
      check_value("valid", 64'(bus.oValid), 64'(exp_valid));
      check_value("pixel", 64'(bus.oPixel), 64'(exp_pix));
      check_value("edge",  64'(bus.oEdge),  64'(exp_edge));
   endtask

   // Drive one cycle at the falling edge, step the model, compare at the next falling edge.
   task automatic run_cycle(input bit ce, input bit sof, input bit en, input int kind);
      logic [W*25-1:0] bits;
      res_t            res;
      bit              border;
      make_window(kind);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) bits[(24 - (5*r + c)) * W +: W] = win[r][c];
      bus.clken   = ce;
      bus.iSof    = sof;
      bus.iEdgeEn = en;
      bus.iGrid   = bits;
      exp_valid   = 1'b0;
      if (ce) begin
         if (sof) begin
            mcol = 0;
            mrow = 0;
         end
         border = (mcol < 4) || (mrow < 4) || !en;
         exp_q.push_back(ref_result(win, border));
         mcol++;
         if (mcol == H) begin
            mcol = 0;
            mrow = (mrow + 1) % V;
         end
         if (exp_q.size() >= 3) begin
            res       = exp_q.pop_front();
            exp_valid = 1'b1;
            exp_pix   = res.pix;
            exp_edge  = res.edge_flag;
         end
      end
      @(negedge clk);
      check_outputs();
      if (exp_valid) begin
         nout++;
         $display("out %0d: pixel=%06h edge=%0b", nout, bus.oPixel, bus.oEdge);
      end
   endtask

   initial begin
      int guard;
      bus.clken   = 1'b0;
      bus.iSof    = 1'b0;
      bus.iEdgeEn = 1'b0;
      bus.iGrid   = '0;
      rst_n       = 1'b0;
      reset_model();
      repeat (3) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Uniform frame: first result after the 3rd enabled edge, never an edge.
      run_cycle(1, 1, 1, 1);
      repeat (19) run_cycle(1, 0, 1, 1);

      // Gapped enable: 1,0,0,1,1 on top of an empty pipeline.
      rst_n = 1'b0;
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(1, 1, 1, 2);
      run_cycle(0, 0, 1, 2);
      run_cycle(0, 0, 1, 2);
      run_cycle(1, 0, 1, 2);
      run_cycle(1, 0, 1, 2);
      repeat (3) run_cycle(1, 0, 1, 2);

      // Walk to an interior position with step windows, then exercise threshold windows.
      guard = 0;
      while (!(mrow == 10 && mcol == 10) && guard < 3000) begin
         run_cycle(1, 0, 1, 2);
         guard++;
      end
      check_value("reach_10_10", 64'(guard < 3000), 64'(1));
      repeat (2) run_cycle(1, 0, 1, 2);
      run_cycle(1, 0, 1, 3);
      run_cycle(1, 0, 1, 4);
      run_cycle(1, 0, 1, 3);
      run_cycle(1, 0, 0, 2);
      repeat (4) run_cycle(1, 0, 1, 4);

      // Long randomized stream with gaps, occasional start of frame and disabled detection.
      repeat (3000)
         run_cycle(($urandom % 4) != 0, ($urandom % 400) == 0,
                   ($urandom % 10) != 0, int'($urandom_range(0, 5)));

      // Mid-frame start of frame at col 100.
      guard = 0;
      while (mcol != 100 && guard < 300) begin
         run_cycle(1, 0, 1, 2);
         guard++;
      end
      check_value("reach_col_100", 64'(guard < 300), 64'(1));
      run_cycle(1, 1, 1, 2);
      repeat (6) run_cycle(1, 0, 1, 2);

      // Asynchronous reset in the middle of a burst.
      repeat (4) run_cycle(1, 0, 1, 2);
      rst_n = 1'b0;
      #1;
      reset_model();
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      repeat (2) run_cycle(1, 0, 1, 0);
      repeat (200)
         run_cycle(($urandom % 3) != 0, 1'b0, 1'b1, int'($urandom_range(0, 5)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/grid_edge_detect.md
Name: grid_edge_detect

Overview:
- Consumer end of the 5x5 line-buffer window interface: samples the 25-tap packed window each enabled cycle and produces one output pixel stream.
- Each output is either the window-centre RGB pixel or, when the local 5x5 gradient magnitude reaches a threshold, a fixed edge colour.
- Sits between the 5-line window buffer and the VGA/output pixel path.
- Tracks frame coordinates so windows straddling frame or line borders are never flagged as edges.

Parameters:
- p_bit_width_in, 24: pixel width; packed R[23:16], G[15:8], B[7:0].
- p_h_active, 640: pixels per line.
- p_v_active, 480: lines per frame.
- p_threshold, 14'd2000: edge threshold on |Gx|+|Gy|.
- p_edge_color, 24'h000000: RGB output for edge pixels.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- clken  in  1  pixel enable; the same enable that advances the window buffer.
- iSof  in  1  start of frame; qualified by clken; marks the current pixel as (0,0).
- iEdgeEn  in  1  0 forces pass-through of the centre pixel.
- iGrid  in  p_bit_width_in*25  window; MSB-first order x00..x04, x10..x44; row 0 is newest, column 4 is newest; x22 is the centre.
- oPixel  out  p_bit_width_in  output pixel.
- oEdge  out  1  oPixel is the edge colour.
- oValid  out  1  one-cycle pulse; oPixel and oEdge are new this cycle.

Behaviour:
- Reset: all pipeline registers, counters, valid bits, oPixel, oEdge and oValid go to 0 asynchronously.
- Pipeline: 3 stages, each advancing only when clken=1.
  - oValid is registered every clk: oValid <= clken & v2, where v1/v2 are the stage valid bits.
  - Data sampled on clken edge k appears with oValid=1 in the cycle after clken edge k+2 (3 enabled edges of latency).
  - When clken=0, all stages and outputs hold, and oValid drops to 0.
- Stage 1:
  - Per tap: I = (R + 2G + B) >> 2, computed in a 10-bit sum and truncated to 8 bits.
  - Register all 25 intensities and the centre RGB x22.
  - Register border flag: b = (col < 4) | (row < 4) | ~iEdgeEn, using counter values at sampling time.
- Stage 2 arithmetic:
  - Row weights wr = {1,2,4,2,1}.
  - Gx = sum over r of wr * (2*(I[r][4]-I[r][0]) + (I[r][3]-I[r][1])).
  - Gy = the same with rows and columns transposed.
  - Gx and Gy are 14-bit signed, range +/-7650; no overflow is possible.
- Stage 3:
  - mag = |Gx| + |Gy|, 14-bit unsigned, max 15300.
  - edge = ~b & (mag >= p_threshold).
  - oPixel = edge ? p_edge_color : centre RGB.
  - oEdge = edge.
- Coordinate counters (col, row) advance on clken:
  - col wraps from p_h_active-1 to 0 and increments row.
  - row wraps from p_v_active-1 to 0.
  - clken & iSof forces the current pixel to (0,0); counters become (1,0) after the edge.
  - iSof mid-frame resynchronises immediately. In-flight pipeline data is unaffected.
- Boundaries:
  - Any window with col<4 or row<4 spans a line or frame wrap, so it is border: pass-through only, never an edge.
  - mag == threshold counts as an edge.
  - Reset mid-stream discards in-flight data; the first oValid after reset needs 3 clken edges.

Decomposition:
- Package grid_pkg holds:
  - constants for tap count (25), intensity width (8) and gradient width (14);
  - row weight constants {1,2,4,2,1};
  - a function mapping (row, col) to the bit offset in iGrid: (24 - (5*row + col)) * p_bit_width_in.
- Sub-module rgb_to_intensity: combinational, 24-bit in, 8-bit out, instantiated 25 times in stage 1.

Test Plan:
- Reset then uniform frame (all taps 24'h808080), iEdgeEn=1 -> Gx=Gy=0; every oPixel=24'h808080, oEdge=0. The first oValid is in the cycle after the 3rd clken edge.
- Vertical step (columns 0-1 at 24'h000000, columns 2-4 at 24'hFFFFFF) at col=10, row=10 -> Gx=2*255*10+255*10=7650, Gy=0 -> oEdge=1, oPixel=24'h000000.
- Same step window at col=2 -> border: oEdge=0, oPixel=centre 24'hFFFFFF. At row=3 -> also pass-through.
- Magnitude exactly 2000 versus 1999 (crafted intensities) -> oEdge=1, then oEdge=0.
- clken toggling 1,0,0,1,1 -> outputs hold and oValid is 0 on disabled cycles; the 3rd enabled edge yields exactly one oValid pulse.
- iSof at col=100 followed by 4 pixels -> edges suppressed for col 0..3. rst_n low mid-pipeline -> oValid=0 and oPixel=0 immediately, with no stale output afterwards.
